mem_wb_pipe: RTL and testbench
==============================

Name: mem_wb_pipe

Overview:
Parametrised MEM->WB pipeline stage, successor to the single-width writeback register.
- Registers memory-stage results through PIPE_DEPTH stages.
- Performs sub-word load alignment with sign or zero extension.
- Supports stall and flush.
- Suppresses writes to register 0.
- Drives the register-file write port and a forwarding bus taken from the last stage.

Parameters:
DATA_W, 32, datapath width; must be a multiple of 8 and >= 32
REG_AW, 5, register address width
PIPE_DEPTH, 1, number of register stages between M inputs and W outputs; legal range 1..4

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
stall  in  1  hold all stages
flush  in  1  replace the incoming entry with a bubble
valid_m  in  1  M-stage entry is a real instruction
reg_write_m  in  1  instruction writes the register file
mem_to_reg_m  in  1  result comes from load data (1) or from the ALU (0)
mem_size_m  in  2  00 byte, 01 half, 10 word32, 11 full DATA_W
mem_sign_m  in  1  1 = sign-extend sub-word load, 0 = zero-extend
addr_low_m  in  $clog2(DATA_W/8)  byte offset of the load address
alu_out_m  in  DATA_W  ALU result
read_data_m  in  DATA_W  raw memory word
write_reg_m  in  REG_AW  destination register
result_w  out  DATA_W  writeback value
write_reg_w  out  REG_AW  writeback destination
reg_write_w  out  1  register-file write enable
valid_w  out  1  W-stage entry is valid
misalign_w  out  1  W-stage entry is a misaligned load

Behaviour:
- Stage 0 capture: the result is computed combinationally from M inputs and registered in stage 0. Stages 1..PIPE_DEPTH-1 are plain shift registers. Outputs are taken from the last stage, so latency = PIPE_DEPTH cycles.
- Load alignment (mem_to_reg_m=1):
  - Lane = read_data_m >> (8*addr_low_m).
  - Byte: lane[7:0]; half: lane[15:0]; word32: lane[31:0]; full: read_data_m unshifted.
  - Extension uses mem_sign_m up to DATA_W.
- ALU path (mem_to_reg_m=0): value = alu_out_m; size, sign and offset inputs are ignored.
- Misalignment: a misaligned load is half with addr_low[0]!=0, or word32 with addr_low[1:0]!=0, or full with addr_low!=0.
  - Stage 0 records misalign=1 and forces reg_write=0.
  - The entry stays valid, and result still carries the shifted value.
- Register 0: reg_write is stored as reg_write_m & valid_m & (write_reg_m!=0).
- Per-cycle priority: rst > flush > stall > advance.
  - rst: every stage's valid, reg_write, misalign, result and write_reg clear to 0. All outputs read 0 in the cycle after rst is sampled high. A rst arriving mid-stream discards all in-flight entries.
  - flush: stage 0 loads a bubble (all fields 0); stages 1.. advance normally. flush overrides a simultaneous stall.
  - stall (flush=0): all stages hold their values; the M inputs are ignored that cycle.
  - advance: stage 0 captures the M inputs; stage k captures stage k-1.
- valid_m=0: the entry is captured as a bubble with valid=0 and reg_write=0. Its result field still holds the computed value (don't-care for checking).
- Outputs are registered only, with no combinational path from inputs to outputs.

Optional Feature:
Macro WB_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_cnt [31:0] and output retire_wr [31:0].
  - retire_cnt increments on each cycle where valid_w=1 and stall=0.
  - retire_wr increments when reg_write_w=1 and stall=0.
  - Both counters reset to 0 on rst and wrap modulo 2^32.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- PIPE_DEPTH=1, ALU op: alu_out_m=0x1234_5678, write_reg_m=3, reg_write_m=1, valid_m=1 -> next cycle result_w=0x1234_5678, write_reg_w=3, reg_write_w=1, valid_w=1.
- Load byte signed: read_data_m=0x80FF_7F01, addr_low=2 -> result_w=0xFFFF_FFFF; same with mem_sign_m=0 -> 0x0000_00FF; half at addr_low=2, signed -> 0xFFFF_80FF.
- Misaligned word32 load, addr_low=1 -> misalign_w=1, reg_write_w=0, valid_w=1.
- write_reg_m=0 with reg_write_m=1 -> reg_write_w=0.
- PIPE_DEPTH=3: entry A presented at cycle 0 -> appears at the outputs after 3 cycles.
  - A stall spanning 2 cycles delays A by exactly 2 cycles with no duplication.
  - flush together with stall on entry B -> B never appears; a bubble occupies its slot.
- Reset mid-stream (PIPE_DEPTH=3, three valid entries in flight) -> all outputs 0 the next cycle; no in-flight entry emerges afterwards.
  - With WB_RETIRE_CNT_EN defined, retire_cnt=0 after reset, then increments by 1 per valid retired entry.

Source files
------------

// File: rtl/mem_wb_pipe_if.sv
// MEM->WB stage bus: M-stage entry and pipeline controls in, W-stage writeback out.
// master drives the M side and observes W; slave is the pipeline stage itself.
interface mem_wb_pipe_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic              stall;
  logic              flush;
  logic              valid_m;
  logic              reg_write_m;
  logic              mem_to_reg_m;
  logic [1:0]        mem_size_m;
  logic              mem_sign_m;
  logic [OFF_W-1:0]  addr_low_m;
  logic [DATA_W-1:0] alu_out_m;
  logic [DATA_W-1:0] read_data_m;
  logic [REG_AW-1:0] write_reg_m;
  logic [DATA_W-1:0] result_w;
  logic [REG_AW-1:0] write_reg_w;
  logic              reg_write_w;
  logic              valid_w;
  logic              misalign_w;

  modport master (
    output stall, flush, valid_m, reg_write_m, mem_to_reg_m, mem_size_m,
           mem_sign_m, addr_low_m, alu_out_m, read_data_m, write_reg_m,
    input  result_w, write_reg_w, reg_write_w, valid_w, misalign_w
  );

  modport slave (
    input  stall, flush, valid_m, reg_write_m, mem_to_reg_m, mem_size_m,
           mem_sign_m, addr_low_m, alu_out_m, read_data_m, write_reg_m,
    output result_w, write_reg_w, reg_write_w, valid_w, misalign_w
  );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline: load alignment/extension, misalign detect, r0 suppression, PIPE_DEPTH stages.
// Optional retire counters are built when WB_RETIRE_CNT_EN is defined.
module mem_wb_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int PIPE_DEPTH = 1
) (
  input  logic                clk,
  input  logic                rst,
  mem_wb_pipe_if.slave        bus
`ifdef WB_RETIRE_CNT_EN
  , output logic [31:0]       retire_cnt
  , output logic [31:0]       retire_wr
`endif
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int LAST  = PIPE_DEPTH - 1;

  function automatic logic [DATA_W-1:0] align_load(
    input logic [DATA_W-1:0] rd,
    input logic [1:0]        size,
    input logic              sgn,
    input logic [OFF_W-1:0]  off
  );
    logic [DATA_W-1:0]        lane;
    logic signed [DATA_W-1:0] ext;
    lane = rd >> {off, 3'b000};
    case (size)
      2'b00:   ext = sgn ? DATA_W'($signed(lane[7:0]))  : DATA_W'(lane[7:0]);
      2'b01:   ext = sgn ? DATA_W'($signed(lane[15:0])) : DATA_W'(lane[15:0]);
      2'b10:   ext = sgn ? DATA_W'($signed(lane[31:0])) : DATA_W'(lane[31:0]);
      default: ext = rd;
    endcase
    return $unsigned(ext);
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [OFF_W-1:0] off);
    case (size)
      2'b01:   return off[0];
      2'b10:   return |off[1:0];
      2'b11:   return |off;
      default: return 1'b0;
    endcase
  endfunction

  logic [DATA_W-1:0] res_c;
  logic              mis_c;
  logic              rw_c;

  assign res_c = bus.mem_to_reg_m
               ? align_load(bus.read_data_m, bus.mem_size_m, bus.mem_sign_m, bus.addr_low_m)
               : bus.alu_out_m;
  assign mis_c = bus.valid_m & bus.mem_to_reg_m & misaligned(bus.mem_size_m, bus.addr_low_m);
  // Misaligned loads still travel down the pipe but never write the register file.
  assign rw_c  = bus.reg_write_m & bus.valid_m & (bus.write_reg_m != '0) & ~mis_c;

  logic [DATA_W-1:0] res_p  [PIPE_DEPTH];
  logic [REG_AW-1:0] wreg_p [PIPE_DEPTH];
  logic              rw_p   [PIPE_DEPTH];
  logic              vld_p  [PIPE_DEPTH];
  logic              mis_p  [PIPE_DEPTH];

  // Stage 0 captures the M entry; stages 1..LAST shift. rst > flush > stall > advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        res_p[k]  <= '0;
        wreg_p[k] <= '0;
        rw_p[k]   <= 1'b0;
        vld_p[k]  <= 1'b0;
        mis_p[k]  <= 1'b0;
      end
    end else if (bus.flush || !bus.stall) begin
      if (bus.flush) begin
        res_p[0]  <= '0;
        wreg_p[0] <= '0;
        rw_p[0]   <= 1'b0;
        vld_p[0]  <= 1'b0;
        mis_p[0]  <= 1'b0;
      end else begin
        res_p[0]  <= res_c;
        wreg_p[0] <= bus.write_reg_m;
        rw_p[0]   <= rw_c;
        vld_p[0]  <= bus.valid_m;
        mis_p[0]  <= mis_c;
      end
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        res_p[k]  <= res_p[k-1];
        wreg_p[k] <= wreg_p[k-1];
        rw_p[k]   <= rw_p[k-1];
        vld_p[k]  <= vld_p[k-1];
        mis_p[k]  <= mis_p[k-1];
      end
    end
  end

  // W stage: outputs come straight from the last register.
  assign bus.result_w    = res_p[LAST];
  assign bus.write_reg_w = wreg_p[LAST];
  assign bus.reg_write_w = rw_p[LAST];
  assign bus.valid_w     = vld_p[LAST];
  assign bus.misalign_w  = mis_p[LAST];

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= '0;
      retire_wr  <= '0;
    end else if (!bus.stall) begin
      if (vld_p[LAST]) retire_cnt <= retire_cnt + 32'd1;
      if (rw_p[LAST])  retire_wr  <= retire_wr + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: depth-1 and depth-3 instances share one stimulus stream,
// each checked against a scoreboard queue of expected W-stage entries.
module tb_mem_wb_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_wb_pipe_if #(.DATA_W(32), .REG_AW(5)) if1 ();
  mem_wb_pipe_if #(.DATA_W(32), .REG_AW(5)) if3 ();

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] rc1, rw1, rc3, rw3;
  int unsigned ec1, ew1, ec3, ew3;
`endif

  mem_wb_pipe #(.DATA_W(32), .REG_AW(5), .PIPE_DEPTH(1)) u1 (
    .clk(clk), .rst(rst), .bus(if1)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(rc1), .retire_wr(rw1)
`endif
  );

  mem_wb_pipe #(.DATA_W(32), .REG_AW(5), .PIPE_DEPTH(3)) u3 (
    .clk(clk), .rst(rst), .bus(if3)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(rc3), .retire_wr(rw3)
`endif
  );

  typedef struct {
    logic        vld, rw, m2r, sgn;
    logic [1:0]  size, off;
    logic [31:0] alu, rd;
    logic [4:0]  wreg;
    logic [31:0] e_res;
    logic        e_rw, e_mis;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  wreg;
    logic        rw, vld, mis;
    bit          full;
  } exp_t;

  localparam exp_t ZERO = '{res: 32'h0, wreg: 5'd0, rw: 1'b0, vld: 1'b0, mis: 1'b0, full: 1'b1};

  vec_t tv [16];
  vec_t idle;
  exp_t q1 [$];
  exp_t q3 [$];
  exp_t cur1, cur3;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  bit   seen_b;

  function automatic vec_t mk(logic vld, logic rw, logic m2r, logic [1:0] size, logic sgn,
                              logic [1:0] off, logic [31:0] alu, logic [31:0] rd, logic [4:0] wreg,
                              logic [31:0] e_res, logic e_rw, logic e_mis);
    vec_t v;
    v.vld = vld; v.rw = rw; v.m2r = m2r; v.size = size; v.sgn = sgn; v.off = off;
    v.alu = alu; v.rd = rd; v.wreg = wreg; v.e_res = e_res; v.e_rw = e_rw; v.e_mis = e_mis;
    return v;
  endfunction

  function automatic exp_t to_exp(vec_t v);
    exp_t e;
    e.res = v.e_res; e.wreg = v.wreg; e.rw = v.e_rw; e.vld = v.vld; e.mis = v.e_mis;
    e.full = v.vld;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic cmp(input string tag, input logic [31:0] res, input logic [4:0] wreg,
                     input logic rw, input logic vld, input logic mis, input exp_t e);
    chk({tag, ".valid_w"}, 32'(vld), 32'(e.vld));
    chk({tag, ".reg_write_w"}, 32'(rw), 32'(e.rw));
    if (e.full) begin
      chk({tag, ".result_w"}, res, e.res);
      chk({tag, ".write_reg_w"}, 32'(wreg), 32'(e.wreg));
      chk({tag, ".misalign_w"}, 32'(mis), 32'(e.mis));
    end
  endtask

  task automatic drive(input vec_t v, input bit st, input bit fl);
    if1.stall = st;          if3.stall = st;
    if1.flush = fl;          if3.flush = fl;
    if1.valid_m = v.vld;     if3.valid_m = v.vld;
    if1.reg_write_m = v.rw;  if3.reg_write_m = v.rw;
    if1.mem_to_reg_m = v.m2r; if3.mem_to_reg_m = v.m2r;
    if1.mem_size_m = v.size; if3.mem_size_m = v.size;
    if1.mem_sign_m = v.sgn;  if3.mem_sign_m = v.sgn;
    if1.addr_low_m = v.off;  if3.addr_low_m = v.off;
    if1.alu_out_m = v.alu;   if3.alu_out_m = v.alu;
    if1.read_data_m = v.rd;  if3.read_data_m = v.rd;
    if1.write_reg_m = v.wreg; if3.write_reg_m = v.wreg;
  endtask

  // One clock: predict, clock, then compare both instances against their scoreboards.
  task automatic step(input exp_t ne);
`ifdef WB_RETIRE_CNT_EN
    if (rst) begin
      ec1 = 0; ew1 = 0; ec3 = 0; ew3 = 0;
    end else if (!if1.stall) begin
      if (if1.valid_w) ec1++;
      if (if1.reg_write_w) ew1++;
      if (if3.valid_w) ec3++;
      if (if3.reg_write_w) ew3++;
    end
`endif
    @(posedge clk);
    #1;
    if (rst) begin
      q1.delete();
      q3.delete();
      q3.push_back(ZERO);
      q3.push_back(ZERO);
      cur1 = ZERO;
      cur3 = ZERO;
    end else if (if1.flush || !if1.stall) begin
      q1.push_back(if1.flush ? ZERO : ne);
      q3.push_back(if1.flush ? ZERO : ne);
      cur1 = q1.pop_front();
      cur3 = q3.pop_front();
    end
    cmp("d1", if1.result_w, if1.write_reg_w, if1.reg_write_w, if1.valid_w, if1.misalign_w, cur1);
    cmp("d3", if3.result_w, if3.write_reg_w, if3.reg_write_w, if3.valid_w, if3.misalign_w, cur3);
    if (if3.valid_w && if3.result_w == 32'hA5A5_0001) seen_b = 1'b1;
`ifdef WB_RETIRE_CNT_EN
    chk("d1.retire_cnt", rc1, ec1);
    chk("d1.retire_wr", rw1, ew1);
    chk("d3.retire_cnt", rc3, ec3);
    chk("d3.retire_wr", rw3, ew3);
`endif
  endtask

  initial begin
    //        vld rw m2r size sgn off  alu            rd             wreg  e_res          e_rw e_mis
    tv[0]  = mk(1, 1, 0, 2'd2, 0, 2'd0, 32'h1234_5678, 32'hDEAD_BEEF, 5'd3,  32'h1234_5678, 1, 0);
    tv[1]  = mk(1, 1, 1, 2'd0, 1, 2'd2, 32'h0,         32'h80FF_7F01, 5'd5,  32'hFFFF_FFFF, 1, 0);
    tv[2]  = mk(1, 1, 1, 2'd0, 0, 2'd2, 32'h0,         32'h80FF_7F01, 5'd6,  32'h0000_00FF, 1, 0);
    tv[3]  = mk(1, 1, 1, 2'd1, 1, 2'd2, 32'h0,         32'h80FF_7F01, 5'd7,  32'hFFFF_80FF, 1, 0);
    tv[4]  = mk(1, 1, 1, 2'd2, 1, 2'd1, 32'h0,         32'h80FF_7F01, 5'd8,  32'h0080_FF7F, 0, 1);
    tv[5]  = mk(1, 1, 0, 2'd2, 0, 2'd0, 32'hCAFE_F00D, 32'h0,         5'd0,  32'hCAFE_F00D, 0, 0);
    tv[6]  = mk(1, 1, 1, 2'd0, 1, 2'd0, 32'h0,         32'h80FF_7F01, 5'd9,  32'h0000_0001, 1, 0);
    tv[7]  = mk(1, 1, 1, 2'd0, 1, 2'd1, 32'h0,         32'h80FF_7F01, 5'd10, 32'h0000_007F, 1, 0);
    tv[8]  = mk(1, 1, 1, 2'd0, 1, 2'd3, 32'h0,         32'h80FF_7F01, 5'd11, 32'hFFFF_FF80, 1, 0);
    tv[9]  = mk(1, 1, 1, 2'd1, 0, 2'd0, 32'h0,         32'h80FF_7F01, 5'd12, 32'h0000_7F01, 1, 0);
    tv[10] = mk(1, 1, 1, 2'd1, 1, 2'd0, 32'h0,         32'h1234_8001, 5'd13, 32'hFFFF_8001, 1, 0);
    tv[11] = mk(1, 1, 1, 2'd3, 1, 2'd0, 32'h0,         32'h80FF_7F01, 5'd14, 32'h80FF_7F01, 1, 0);
    tv[12] = mk(1, 0, 0, 2'd2, 0, 2'd0, 32'h0BAD_CAFE, 32'h0,         5'd15, 32'h0BAD_CAFE, 0, 0);
    tv[13] = mk(1, 1, 1, 2'd2, 1, 2'd0, 32'h0,         32'h80FF_7F01, 5'd31, 32'h80FF_7F01, 1, 0);
    tv[14] = mk(0, 1, 0, 2'd2, 0, 2'd0, 32'h1111_2222, 32'h0,         5'd4,  32'h1111_2222, 0, 0);
    tv[15] = mk(1, 1, 0, 2'd0, 1, 2'd3, 32'hA5A5_0001, 32'hFFFF_FFFF, 5'd16, 32'hA5A5_0001, 1, 0);
    idle   = mk(0, 0, 0, 2'd0, 0, 2'd0, 32'h0,         32'h0,         5'd0,  32'h0,         0, 0);
    seen_b = 1'b0;

    drive(idle, 0, 0);
    rst = 1'b1;
    step(ZERO);
    step(ZERO);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(tv[i], 0, 0);
      step(to_exp(tv[i]));
    end
    drive(idle, 0, 0);
    for (int i = 0; i < 3; i++) step(to_exp(idle));

    // Two-cycle stall right behind entry A.
    drive(tv[0], 0, 0);
    step(to_exp(tv[0]));
    drive(tv[1], 1, 0);
    step(to_exp(tv[1]));
    step(to_exp(tv[1]));
    drive(idle, 0, 0);
    for (int i = 0; i < 4; i++) step(to_exp(idle));

    // Entry B presented with flush and stall together must never retire.
    seen_b = 1'b0;
    drive(tv[3], 0, 0);
    step(to_exp(tv[3]));
    drive(tv[15], 1, 1);
    step(to_exp(tv[15]));
    drive(tv[11], 0, 0);
    step(to_exp(tv[11]));
    drive(idle, 0, 0);
    for (int i = 0; i < 4; i++) step(to_exp(idle));
    chk("flushed_entry_absent", 32'(seen_b), 32'd0);

    // Reset with three valid entries in flight.
    drive(tv[0], 0, 0);
    step(to_exp(tv[0]));
    drive(tv[3], 0, 0);
    step(to_exp(tv[3]));
    drive(tv[6], 0, 0);
    step(to_exp(tv[6]));
    drive(tv[7], 0, 0);
    rst = 1'b1;
    step(ZERO);
    rst = 1'b0;
    drive(idle, 0, 0);
    for (int i = 0; i < 4; i++) step(to_exp(idle));
    drive(tv[9], 0, 0);
    step(to_exp(tv[9]));
    drive(idle, 0, 0);
    for (int i = 0; i < 3; i++) step(to_exp(idle));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
